// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_pkg
// Shared definitions for the register-file write-back arbiter:
//   - wb_sel_e    : register-file source select encodings (WB_PC/WB_ALU/WB_MEM)
//   - SRC_*       : source index constants (PC=0, ALU=1, MEM=2)
//   - pick_first  : returns a one-hot grant for the first requesting source
//                   found in a given three-entry search order
// ---------------------------------------------------------------------------
package regfile_wb_arbiter_pkg;

   typedef enum logic [1:0] {
      WB_PC  = 2'b00,
      WB_ALU = 2'b01,
      WB_MEM = 2'b10
   } wb_sel_e;

   localparam logic [1:0] SRC_PC  = 2'd0;
   localparam logic [1:0] SRC_ALU = 2'd1;
   localparam logic [1:0] SRC_MEM = 2'd2;

   // First requester in the order first, second, third wins; none -> 3'b000.
   function automatic logic [2:0] pick_first(
      input logic [2:0] req,
      input logic [1:0] first,
      input logic [1:0] second,
      input logic [1:0] third
   );
      logic [2:0] g;
      g = 3'b000;
      if (req[first]) begin
         g = 3'b001 << first;
      end else if (req[second]) begin
         g = 3'b001 << second;
      end else if (req[third]) begin
         g = 3'b001 << third;
      end else begin
         g = 3'b000;
      end
      return g;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_picker.sv
// ---------------------------------------------------------------------------
// wb_rr_picker
// Three-request grant picker for the write-back arbiter. Purely combinational.
//   req        in  3  gated requests (bit index = source index)
//   last_grant in  2  index of the last granted source (WB_ARB_RR_EN only)
//   gnt        out 3  one-hot grant, zero when nothing requests
// Build option WB_ARB_RR_EN: round-robin starting after last_grant.
// Default build: fixed priority MEM > ALU > PC, no pointer input.
// ---------------------------------------------------------------------------
module wb_rr_picker
   import regfile_wb_arbiter_pkg::*;
(
   input  logic [2:0] req,
`ifdef WB_ARB_RR_EN
   input  logic [1:0] last_grant,
`endif
   output logic [2:0] gnt
);

   // Choose the search order and grant the first requester in it.
   always_comb begin
      gnt = 3'b000;
`ifdef WB_ARB_RR_EN
      case (last_grant)
         SRC_PC:  gnt = pick_first(req, SRC_ALU, SRC_MEM, SRC_PC);
         SRC_ALU: gnt = pick_first(req, SRC_MEM, SRC_PC,  SRC_ALU);
         SRC_MEM: gnt = pick_first(req, SRC_PC,  SRC_ALU, SRC_MEM);
         // Pointer never holds 3; behave as after an ALU grant.
         default: gnt = pick_first(req, SRC_MEM, SRC_PC,  SRC_ALU);
      endcase
`else
      gnt = pick_first(req, SRC_MEM, SRC_ALU, SRC_PC);
`endif
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates three write-back sources (PC+4 link, ALU, load) onto a single
// register-file write port with one registered output stage.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   {pc,alu,mem}_valid/rd/data  per-source write-back request
//   {pc,alu,mem}_ready          combinational grant (transfer on valid&&ready)
//   wb_stall                    blocks new grants while high
//   write_enable, rd, WBSel     registered register-file controls
//   PC, ALU_out, dmem_out       registered data; only the selected one nonzero
//   q_rs1/q_rs2 -> q_busy1/2    combinational pending-write hazard query
// Build option WB_ARB_RR_EN selects round-robin arbitration (pointer resets
// to ALU); otherwise fixed priority MEM > ALU > PC without pointer state.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
   import regfile_wb_arbiter_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_valid,
   input  logic [4:0]      pc_rd,
   input  logic [XLEN-1:0] pc_data,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            mem_valid,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            pc_ready,
   output logic            alu_ready,
   output logic            mem_ready,
   input  logic            wb_stall,
   output logic            write_enable,
   output logic [4:0]      rd,
   output logic [1:0]      WBSel,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] ALU_out,
   output logic [XLEN-1:0] dmem_out,
   input  logic [4:0]      q_rs1,
   input  logic [4:0]      q_rs2,
   output logic            q_busy1,
   output logic            q_busy2
);

   logic [2:0]      req_s;
   logic [2:0]      gnt_s;
   logic            xfer_s;
   wb_sel_e         sel_src_s;
   logic [4:0]      sel_rd_s;
   logic [XLEN-1:0] sel_data_s;

   logic            we_r;
   logic [4:0]      rd_r;
   wb_sel_e         wbsel_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] alu_r;
   logic [XLEN-1:0] mem_r;

   // Register q is pending if the output stage or any live request targets it.
   function automatic logic hazard(
      input logic [4:0] q,
      input logic       out_we,
      input logic [4:0] out_rd,
      input logic [2:0] v,
      input logic [4:0] r0,
      input logic [4:0] r1,
      input logic [4:0] r2
   );
      logic b;
      b = 1'b0;
      if (q != 5'd0) begin
         b = (out_we && (out_rd == q)) ||
             (v[0] && (r0 == q)) ||
             (v[1] && (r1 == q)) ||
             (v[2] && (r2 == q));
      end else begin
         b = 1'b0;
      end
      return b;
   endfunction

   // Stall and reset suppress every request before it reaches the picker.
   assign req_s = {mem_valid, alu_valid, pc_valid} & {3{~wb_stall & ~rst}};

`ifdef WB_ARB_RR_EN
   logic [1:0] last_grant_r;

   wb_rr_picker u_picker (
      .req        (req_s),
      .last_grant (last_grant_r),
      .gnt        (gnt_s)
   );

   // Round-robin pointer: reset to ALU, advance only on a transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_r <= SRC_ALU;
      end else begin
         case (gnt_s)
            3'b001:  last_grant_r <= SRC_PC;
            3'b010:  last_grant_r <= SRC_ALU;
            3'b100:  last_grant_r <= SRC_MEM;
            default: last_grant_r <= last_grant_r;
         endcase
      end
   end
`else
   wb_rr_picker u_picker (
      .req (req_s),
      .gnt (gnt_s)
   );
`endif

   assign pc_ready  = gnt_s[0];
   assign alu_ready = gnt_s[1];
   assign mem_ready = gnt_s[2];
   assign xfer_s    = |gnt_s;

   // Mux the granted source's destination, data and select encoding.
   always_comb begin
      sel_src_s  = WB_PC;
      sel_rd_s   = 5'd0;
      sel_data_s = {XLEN{1'b0}};
      case (gnt_s)
         3'b001: begin
            sel_src_s  = WB_PC;
            sel_rd_s   = pc_rd;
            sel_data_s = pc_data;
         end
         3'b010: begin
            sel_src_s  = WB_ALU;
            sel_rd_s   = alu_rd;
            sel_data_s = alu_data;
         end
         3'b100: begin
            sel_src_s  = WB_MEM;
            sel_rd_s   = mem_rd;
            sel_data_s = mem_data;
         end
         default: begin
            sel_src_s  = WB_PC;
            sel_rd_s   = 5'd0;
            sel_data_s = {XLEN{1'b0}};
         end
      endcase
   end

   // Single output stage; idle cycles and reset present all-zero outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_r    <= 1'b0;
         rd_r    <= 5'd0;
         wbsel_r <= WB_PC;
         pc_r    <= {XLEN{1'b0}};
         alu_r   <= {XLEN{1'b0}};
         mem_r   <= {XLEN{1'b0}};
      end else if (xfer_s) begin
         // x0 writes are consumed but never reach the register file.
         we_r    <= (sel_rd_s != 5'd0);
         rd_r    <= sel_rd_s;
         wbsel_r <= sel_src_s;
         pc_r    <= (sel_src_s == WB_PC)  ? sel_data_s : {XLEN{1'b0}};
         alu_r   <= (sel_src_s == WB_ALU) ? sel_data_s : {XLEN{1'b0}};
         mem_r   <= (sel_src_s == WB_MEM) ? sel_data_s : {XLEN{1'b0}};
      end else begin
         we_r    <= 1'b0;
         rd_r    <= 5'd0;
         wbsel_r <= WB_PC;
         pc_r    <= {XLEN{1'b0}};
         alu_r   <= {XLEN{1'b0}};
         mem_r   <= {XLEN{1'b0}};
      end
   end

   assign write_enable = we_r;
   assign rd           = rd_r;
   assign WBSel        = wbsel_r;
   assign PC           = pc_r;
   assign ALU_out      = alu_r;
   assign dmem_out     = mem_r;

   assign q_busy1 = hazard(q_rs1, we_r, rd_r, {mem_valid, alu_valid, pc_valid},
                           pc_rd, alu_rd, mem_rd);
   assign q_busy2 = hazard(q_rs2, we_r, rd_r, {mem_valid, alu_valid, pc_valid},
                           pc_rd, alu_rd, mem_rd);

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the width of every data bus.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset, synchronous and active-high.
REQ-004 pc_valid / alu_valid / mem_valid  in  1 each  SHALL be the write-back request from the link (PC+4), ALU and load sources.
REQ-005 pc_rd / alu_rd / mem_rd  in  5 each  SHALL be the destination register of each request.
REQ-006 pc_data / alu_data / mem_data  in  XLEN each  SHALL be the write-back value of each request.
REQ-007 pc_ready / alu_ready / mem_ready  out  1 each  SHALL be the combinational per-source grant, transfer when valid && ready.
REQ-008 wb_stall  in  1  SHALL be the pipeline stall input; no grants while high.
REQ-009 write_enable  out  1  SHALL drive the register file write enable.
REQ-010 rd  out  5  SHALL drive the register file destination.
REQ-011 WBSel  out  2  SHALL drive the register file source select: 00 PC, 01 ALU, 10 dmem; 11 never driven.
REQ-012 PC / ALU_out / dmem_out  out  XLEN each  SHALL drive the register file data inputs.
REQ-013 q_rs1 / q_rs2  in  5 each, q_busy1 / q_busy2  out  1 each  SHALL form the pending-write hazard query.

Function
REQ-014 At most one source SHALL be granted per cycle; grant only when wb_stall=0 and that source's valid=1.
REQ-015 Source index SHALL be PC=0, ALU=1, MEM=2.
REQ-016 Latency SHALL be 1 cycle: a transfer in cycle N SHALL drive write_enable/rd/WBSel/data from registers in cycle N+1.
REQ-017 The granted value SHALL appear only on the data output matching WBSel; the other two data outputs SHALL be 0.
REQ-018 In a cycle with no transfer, the next cycle SHALL have write_enable=0, rd=0, WBSel=00 and all data outputs 0.
REQ-019 A request with rd=0 SHALL be granted and consumed normally, but its output cycle SHALL have write_enable=0.
REQ-020 Sources SHALL hold valid, rd and data stable until ready; the arbiter SHALL NOT buffer more than the single output stage.
REQ-021 q_busyN SHALL be 1 iff q_rsN!=0 and q_rsN equals either (a) rd of the output stage with write_enable=1, or (b) rd of any source with valid=1; combinational.
REQ-022 Two sources requesting the same rd in one cycle SHALL be serialised per arbitration order; the later grant SHALL overwrite the earlier one.
REQ-023 wb_stall asserted SHALL block new grants only; an already-registered output SHALL still be presented in the following cycle.

Reset
REQ-024 While rst=1 at a clock edge, all outputs registered by the block SHALL become 0: write_enable, rd, WBSel, PC, ALU_out, dmem_out.
REQ-025 While rst=1, all ready outputs SHALL be 0.
REQ-026 While rst=1, the round-robin last-grant pointer SHALL be set to 1 (ALU).
REQ-027 rst asserted mid-transfer SHALL discard the output stage; the source SHALL re-present its request after reset.

Configuration
REQ-028 With WB_ARB_RR_EN defined, arbitration SHALL be round-robin: search starts at (last_grant+1) mod 3; the pointer updates only on a transfer.
REQ-029 Without WB_ARB_RR_EN, arbitration SHALL be fixed priority MEM > ALU > PC and no pointer state SHALL exist.

Structure
REQ-030 A shared package SHALL hold the WBSel encodings (WB_PC, WB_ALU, WB_MEM) and the source index constants.
REQ-031 One sub-module, wb_rr_picker (3-request priority/round-robin picker with pointer input), SHALL implement grant selection.

Verification
REQ-032 Bench SHALL check: ALU only, alu_rd=5, alu_data=10 -> alu_ready=1 same cycle; next cycle write_enable=1, rd=5, WBSel=01, ALU_out=10, PC=0, dmem_out=0.
REQ-033 Bench SHALL check: all three valid (pc_rd=3, alu_rd=5, mem_rd=4), RR build -> grants MEM, PC, ALU on consecutive cycles; fixed build -> MEM, ALU, PC.
REQ-034 Bench SHALL check: alu_rd=0, alu_data=10 -> alu_ready=1; next cycle write_enable=0, rd=0.
REQ-035 Bench SHALL check: wb_stall=1 with mem_valid=1 for 3 cycles -> mem_ready=0 throughout; stall released -> grant next cycle, dmem_out=13 one cycle later.
REQ-036 Bench SHALL check: alu_valid=1, alu_rd=7, q_rs1=7, q_rs2=0 -> q_busy1=1, q_busy2=0; q_busy1 SHALL remain 1 through the output cycle and drop after.
REQ-037 Bench SHALL check: rst=1 on the cycle after a grant -> following cycle all outputs 0 and write_enable=0.
